// File: rtl/tlul_pkg.sv
// Shared TL-UL widths and the integrity-buffer entry type.
package tlul_pkg;

  localparam int unsigned DataMaxWidth  = 32;
  localparam int unsigned DataIntgWidth = 7;
  localparam int unsigned DataIntgTotal = DataMaxWidth + DataIntgWidth;

  // Integrity bits are stored inverted so an all-zero word is never a valid codeword.
  localparam logic [DataIntgTotal-1:0] IntgInvMask = 39'h2A_0000_0000;

  typedef struct packed {
    logic [DataMaxWidth-1:0] data;
    logic                    err;
  } rsp_intg_entry_t;

  function automatic logic [DataMaxWidth-1:0] intg_data(
    input logic [DataIntgTotal-1:0] word
  );
    return word[DataMaxWidth-1:0];
  endfunction

endpackage

// File: rtl/tlul_data_integ_dec.sv
// Inverted 39/32 Hsiao SECDED syndrome check; flags only, no correction.
module tlul_data_integ_dec
  import tlul_pkg::*;
(
  input  logic [DataIntgTotal-1:0] i_data_intg,
  output logic                     o_single_err,
  output logic                     o_double_err
);

  logic [DataIntgTotal-1:0] w_raw;
  logic [DataIntgWidth-1:0] w_syndrome;

  assign w_raw = i_data_intg ^ IntgInvMask;

  always_comb begin
    w_syndrome    = '0;
    w_syndrome[0] = ^(w_raw & 39'h01_2606_BD25);
    w_syndrome[1] = ^(w_raw & 39'h02_DEBA_8050);
    w_syndrome[2] = ^(w_raw & 39'h04_413D_89AA);
    w_syndrome[3] = ^(w_raw & 39'h08_3123_4ED1);
    w_syndrome[4] = ^(w_raw & 39'h10_C2C1_323B);
    w_syndrome[5] = ^(w_raw & 39'h20_2DCC_624C);
    w_syndrome[6] = ^(w_raw & 39'h40_9850_5586);
  end

  // Hsiao columns have odd weight: odd syndrome means single, even non-zero means double.
  assign o_single_err = ^w_syndrome;
  assign o_double_err = (|w_syndrome) & ~(^w_syndrome);

endmodule

// File: rtl/tlul_rsp_intg_buf.sv
// D-channel response FIFO that tags each beat with its integrity error and tracks errors.
// Define TLUL_RSP_INTG_CNT_EN to build the saturating error counter.
module tlul_rsp_intg_buf
  import tlul_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter int unsigned CntWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rsp_valid_i,
  output logic                     rsp_ready_o,
  input  logic [DataIntgTotal-1:0] rsp_data_intg_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DataMaxWidth-1:0]  rsp_data_o,
  output logic                     rsp_err_o,
  output logic                     err_pulse_o,
  output logic                     err_sticky_o,
  input  logic                     err_clr_i,
  output logic [CntWidth-1:0]      err_cnt_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  rsp_intg_entry_t r_mem [Depth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [OccW-1:0] r_cnt;
  logic            r_err_pulse, r_err_sticky;

  logic            w_single_err, w_double_err, w_err;
  logic            w_push, w_pop, w_bad_push;
  rsp_intg_entry_t w_entry;

  tlul_data_integ_dec u_dec (
    .i_data_intg  (rsp_data_intg_i),
    .o_single_err (w_single_err),
    .o_double_err (w_double_err)
  );

  assign w_err       = w_single_err | w_double_err;
  assign rsp_ready_o = (r_cnt != OccW'(Depth));
  assign rsp_valid_o = (r_cnt != '0);
  assign w_push      = rsp_valid_i & rsp_ready_o;
  assign w_pop       = rsp_valid_o & rsp_ready_i;
  assign w_bad_push  = w_push & w_err;

  assign w_entry.data = intg_data(rsp_data_intg_i);
  assign w_entry.err  = w_err;

  // Storage is not reset; the occupancy count alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign rsp_data_o = r_mem[r_rptr].data;
  assign rsp_err_o  = rsp_valid_o & r_mem[r_rptr].err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_pulse <= w_bad_push;
      if (w_bad_push)     r_err_sticky <= 1'b1;
      else if (err_clr_i) r_err_sticky <= 1'b0;
    end
  end

  assign err_pulse_o  = r_err_pulse;
  assign err_sticky_o = r_err_sticky;

`ifdef TLUL_RSP_INTG_CNT_EN
  logic [CntWidth-1:0] r_err_cnt;

  // A clear coinciding with a new error keeps that error counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (w_bad_push) begin
      if (err_clr_i)        r_err_cnt <= CntWidth'(1);
      else if (~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
    end else if (err_clr_i) begin
      r_err_cnt <= '0;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tlul_rsp_intg_buf.sv
// Directed self-checking bench for tlul_rsp_intg_buf (default Depth=2, CntWidth=8).
module tb_tlul_rsp_intg_buf;

`ifdef TLUL_RSP_INTG_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        rsp_valid_i = 1'b0;
  logic        rsp_ready_o;
  logic [38:0] rsp_data_intg_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        err_pulse_o;
  logic        err_sticky_o;
  logic        err_clr_i = 1'b0;
  logic [7:0]  err_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  tlul_rsp_intg_buf dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rsp_valid_i     (rsp_valid_i),
    .rsp_ready_o     (rsp_ready_o),
    .rsp_data_intg_i (rsp_data_intg_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_data_o      (rsp_data_o),
    .rsp_err_o       (rsp_err_o),
    .err_pulse_o     (err_pulse_o),
    .err_sticky_o    (err_sticky_o),
    .err_clr_i       (err_clr_i),
    .err_cnt_o       (err_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Valid codewords (data 0..3) and single-bit-flipped error words (data 1<<i).
  function automatic logic [38:0] beat_word(input int i);
    case (i)
      0:       return 39'h2A_0000_0000;
      1:       return 39'h33_0000_0001;
      2:       return 39'h7E_0000_0002;
      3:       return 39'h67_0000_0003;
      default: return 39'h2A_0000_0000 | (39'h1 << i);
    endcase
  endfunction

  function automatic logic [31:0] beat_data(input int i);
    return (i < 4) ? 32'(i) : (32'h1 << i);
  endfunction

  function automatic logic beat_err(input int i);
    return (i >= 4);
  endfunction

  initial begin
    // Reset state
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst_valid", rsp_valid_o, 0);
    check("rst_ready", rsp_ready_o, 1);
    check("rst_sticky", err_sticky_o, 0);
    check("rst_cnt", err_cnt_o, 0);
    check("rst_pulse", err_pulse_o, 0);

    // Clean beat, one-cycle latency
    rsp_ready_i = 1'b1;
    rsp_valid_i = 1'b1;
    rsp_data_intg_i = 39'h2A_0000_0000;
    check("no_bypass", rsp_valid_o, 0);
    step();
    rsp_valid_i = 1'b0;
    check("good_valid", rsp_valid_o, 1);
    check("good_data", rsp_data_o, 0);
    check("good_err", rsp_err_o, 0);
    check("good_pulse", err_pulse_o, 0);
    step();
    check("good_drained", rsp_valid_o, 0);

    // Single-bit flip
    rsp_valid_i = 1'b1;
    rsp_data_intg_i = 39'h2A_0000_0001;
    step();
    rsp_valid_i = 1'b0;
    check("bad_err", rsp_err_o, 1);
    check("bad_data", rsp_data_o, 1);
    check("bad_pulse", err_pulse_o, 1);
    check("bad_sticky", err_sticky_o, 1);
    check("bad_cnt", err_cnt_o, CntEn ? 1 : 0);
    step();
    check("pulse_one_cycle", err_pulse_o, 0);
    check("sticky_held", err_sticky_o, 1);
    check("err_when_idle", rsp_err_o, 0);

    // Ignored data when not valid
    rsp_data_intg_i = 39'h00_0000_00FF;
    step();
    check("ignore_pulse", err_pulse_o, 0);
    check("ignore_valid", rsp_valid_o, 0);

    // Backpressure: fill, hold third beat, drain in order
    rsp_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_data_intg_i = beat_word(1);
    step();
    check("fill1_ready", rsp_ready_o, 1);
    rsp_data_intg_i = beat_word(2);
    step();
    check("full_ready", rsp_ready_o, 0);
    rsp_data_intg_i = beat_word(3);
    step();
    check("full_hold_ready", rsp_ready_o, 0);
    check("stall_data", rsp_data_o, 1);
    check("stall_err", rsp_err_o, 0);
    rsp_ready_i = 1'b1;
    step();
    check("drain_b", rsp_data_o, 2);
    step();
    rsp_valid_i = 1'b0;
    check("drain_c", rsp_data_o, 3);
    check("drain_c_valid", rsp_valid_o, 1);
    step();
    check("drain_empty", rsp_valid_o, 0);

    // Count stays 1 under push+pop, order preserved across wrap
    rsp_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_data_intg_i = beat_word(0);
    step();
    rsp_ready_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      rsp_data_intg_i = beat_word(i);
      check($sformatf("wrap_data%0d", i - 1), rsp_data_o, beat_data(i - 1));
      check($sformatf("wrap_err%0d", i - 1), rsp_err_o, beat_err(i - 1));
      step();
      check($sformatf("wrap_occ%0d", i), {rsp_valid_o, rsp_ready_o}, 2'b11);
    end
    rsp_valid_i = 1'b0;
    check("wrap_last", rsp_data_o, beat_data(10));
    step();
    check("wrap_empty", rsp_valid_o, 0);

    // Clear alone, then clear coinciding with an error
    err_clr_i = 1'b1;
    step();
    check("clr_sticky", err_sticky_o, 0);
    check("clr_cnt", err_cnt_o, 0);
    rsp_valid_i = 1'b1;
    rsp_data_intg_i = 39'h2A_0000_0004;
    step();
    err_clr_i = 1'b0;
    check("clr_set_sticky", err_sticky_o, 1);
    check("clr_set_cnt", err_cnt_o, CntEn ? 1 : 0);
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 253) check("cnt_254", err_cnt_o, CntEn ? 254 : 0);
      if (k == 254) check("cnt_255", err_cnt_o, CntEn ? 255 : 0);
    end
    rsp_valid_i = 1'b0;
    step();
    check("cnt_sat", err_cnt_o, CntEn ? 255 : 0);

    // Reset with two beats buffered
    rsp_ready_i = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_data_intg_i = beat_word(1);
    step();
    step();
    rsp_valid_i = 1'b0;
    check("pre_rst_ready", rsp_ready_o, 0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid_rst_valid", rsp_valid_o, 0);
    check("mid_rst_ready", rsp_ready_o, 1);
    check("mid_rst_sticky", err_sticky_o, 0);
    check("mid_rst_cnt", err_cnt_o, 0);
    check("mid_rst_err", rsp_err_o, 0);
    rsp_ready_i = 1'b1;
    step();
    check("post_rst_empty", rsp_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
